// File: rtl/bus_arbiter2.sv
// ----------------------------------------------------------------------------
// bus_arbiter2
// Two-requester round-robin bus arbiter with a registered grant, a shared
// 2:1 bus mux and beat-count based preemption of long transfers.
//
// Parameters
//   busSize   width of the data bus
//   maxBeats  accepted beats (1..255) after which the owner can be preempted
//
// Ports
//   clk, rst          clock (rising edge) / asynchronous active-high reset
//   req0, req1        requester wants or holds the bus
//   data0, data1      requester beat data
//   last0, last1      current beat is the requester's final beat
//   busReady          downstream accepts the beat this cycle
//   gnt0, gnt1        registered ownership grant
//   sel               mux select (0 = requester 0, 1 = requester 1)
//   busValid, busLast, busData  muxed bus toward downstream
//   preempt           one-cycle pulse on the cycle of a forced release
//   beatCnt           accepted beats in the current ownership (saturates 255)
// ----------------------------------------------------------------------------
module bus_arbiter2 #(
  parameter int busSize  = 8,
  parameter int maxBeats = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [busSize-1:0] data0,
  input  logic [busSize-1:0] data1,
  input  logic               last0,
  input  logic               last1,
  input  logic               busReady,
  output logic               gnt0,
  output logic               gnt1,
  output logic               sel,
  output logic               busValid,
  output logic               busLast,
  output logic [busSize-1:0] busData,
  output logic               preempt,
  output logic [7:0]         beatCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [8:0] beat_limit = 9'(maxBeats);

  state_t     state;
  state_t     state_next;
  logic       sel_reg;
  logic       sel_next;
  logic       last_owner;
  logic       last_owner_next;
  logic [7:0] beat_cnt;
  logic [7:0] beat_cnt_next;
  logic       force_release;

  logic       owner_id;
  logic       owner_last;
  logic       other_req;
  logic       valid_int;
  logic       accept;
  logic       limit_reached;
  state_t     other_state;

  // Owner-relative views so the next-state logic is written once for
  // both OWN states. In IDLE valid_int is 0, so the rest is don't-care.
  assign owner_id      = (state == OWN1);
  assign owner_last    = owner_id ? last1 : last0;
  assign other_req     = owner_id ? req0 : req1;
  assign other_state   = owner_id ? OWN0 : OWN1;
  assign valid_int     = ((state == OWN0) && req0) || ((state == OWN1) && req1);
  assign accept        = valid_int && busReady;
  // True when this accepted beat brings the count to (or keeps it at or
  // above) the preemption threshold; 9 bits so 255 + 1 cannot wrap.
  assign limit_reached = (({1'b0, beat_cnt} + 9'd1) >= beat_limit);

  // State register: arbitration state, held mux select, round-robin
  // pointer and beat counter. Reset makes requester 0 the first winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel_reg    <= 1'b0;
      last_owner <= 1'b1;
      beat_cnt   <= 8'd0;
    end else begin
      state      <= state_next;
      sel_reg    <= sel_next;
      last_owner <= last_owner_next;
      beat_cnt   <= beat_cnt_next;
    end
  end

  // Next-state logic. A last beat always wins over preemption, so a
  // finishing owner never produces a preempt pulse. Releases hand over
  // directly to a waiting requester without an idle cycle.
  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    beat_cnt_next   = beat_cnt;
    force_release   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_next = last_owner ? OWN0 : OWN1;
        end else if (req0) begin
          state_next = OWN0;
        end else if (req1) begin
          state_next = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (accept) begin
          if (owner_last) begin
            state_next      = other_req ? other_state : IDLE;
            last_owner_next = owner_id;
            beat_cnt_next   = 8'd0;
          end else if (other_req && limit_reached) begin
            state_next      = other_state;
            force_release   = 1'b1;
            last_owner_next = owner_id;
            beat_cnt_next   = 8'd0;
          end else if (beat_cnt != 8'hFF) begin
            beat_cnt_next = beat_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The mux select follows the owner and keeps its value through IDLE.
    sel_next = sel_reg;
    if (state_next == OWN0) begin
      sel_next = 1'b0;
    end else if (state_next == OWN1) begin
      sel_next = 1'b1;
    end
  end

  // Output logic: grants decode the registered state, the bus is a plain
  // mux of the selected requester gated by ownership.
  always_comb begin
    gnt0     = (state == OWN0);
    gnt1     = (state == OWN1);
    sel      = sel_reg;
    busValid = valid_int;
    busLast  = owner_last && valid_int;
    busData  = sel_reg ? data1 : data0;
    preempt  = force_release;
    beatCnt  = beat_cnt;
  end

endmodule

// File: doc/bus_arbiter2.md
BUS_ARBITER2 -- requirements
Module: bus_arbiter2

Interface
REQ-001 SHALL have parameter busSize, default 8, giving the width of the data bus.
REQ-002 SHALL have parameter maxBeats, default 16 (legal range 1..255), giving the accepted beats before the owner becomes preemptible.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports req0, req1  input  1 each  requester wants or holds the bus.
REQ-006 SHALL have ports data0, data1  input  busSize each  requester beat data.
REQ-007 SHALL have ports last0, last1  input  1 each  current beat is the requester's final beat.
REQ-008 SHALL have port busReady  input  1  downstream accepts the beat this cycle.
REQ-009 SHALL have ports gnt0, gnt1  output  1 each  registered ownership grant.
REQ-010 SHALL have port sel  output  1  select for the shared 2:1 bus mux (0 = requester 0, 1 = requester 1).
REQ-011 SHALL have ports busValid, busLast  output  1 each, and port busData  output  busSize  the muxed bus.
REQ-012 SHALL have port preempt  output  1  one-cycle pulse on forced release.
REQ-013 SHALL have port beatCnt  output  8  accepted beats in the current ownership.

Function
REQ-014 SHALL implement states IDLE, OWN0 and OWN1; gnt0 = (state == OWN0) and gnt1 = (state == OWN1).
REQ-015 SHALL maintain a 1-bit pointer lastOwner; when both requests are seen in IDLE, the requester other than lastOwner wins.
REQ-016 In IDLE with exactly one request asserted, SHALL enter that requester's OWN state at the next edge; grant latency is 1 cycle from req.
REQ-017 sel SHALL be 1 in OWN1, 0 in OWN0, and SHALL hold its previous value in IDLE.
REQ-018 busData SHALL equal data0 when sel = 0 and data1 when sel = 1 (combinational); busValid SHALL equal reqX & gntX for the owner and 0 in IDLE; busLast SHALL equal lastX & busValid.
REQ-019 A beat is accepted when busValid & busReady; only accepted beats SHALL increment beatCnt, which saturates at 255.
REQ-020 An accepted beat with last SHALL release ownership: go directly to the other OWN state (no idle cycle) if the other req is high at that edge, else to IDLE; lastOwner SHALL become the releasing requester and beatCnt SHALL clear.
REQ-021 An owner deasserting req without last SHALL keep ownership (busValid = 0) until it finishes.
REQ-022 When an accepted beat makes beatCnt reach maxBeats without last and the other req is high, SHALL force release to the other OWN state, pulse preempt for 1 cycle, update lastOwner and clear beatCnt.
REQ-023 If the other req is low in that case, the owner SHALL continue with no preempt, and SHALL be preempted on any later accepted beat while beatCnt ≥ maxBeats and the other req is high.
REQ-024 A last beat coinciding with the preemption condition SHALL count as a normal release, with preempt = 0.
REQ-025 The non-owner's data and last SHALL be ignored; busReady low SHALL stall with the state, beatCnt and sel unchanged.

Reset
REQ-026 While rst = 1 (asynchronous, without a clock edge), SHALL force state = IDLE, gnt0 = gnt1 = 0, sel = 0, busValid = 0, busLast = 0, preempt = 0, beatCnt = 0 and lastOwner = 1 (requester 0 wins first).
REQ-027 Reset asserted mid-transfer SHALL abort the transfer immediately; after release, arbitration SHALL restart from IDLE.

Verification
REQ-028 After reset, req0 = 1 only with busReady = 1 and last0 on the 3rd beat -> gnt0 = 1 one cycle later; 3 beats are accepted with busLast on beat 3; gnt0 = 0 and IDLE at the next edge.
REQ-029 req0 = req1 = 1 from reset, each sending 2 beats -> OWN0 first; gnt1 rises on the edge after last0 with no idle cycle; both requesting again afterwards -> OWN0.
REQ-030 busReady = 0 for 3 cycles mid-transfer with data1 = 8'hA5 -> busData holds 8'hA5, beatCnt is unchanged, sel = 1 and gnt1 stays high.
REQ-031 maxBeats = 4, req0 streaming without last, req1 = 1 -> preempt pulses 1 cycle at the 4th accepted beat, gnt1 = 1 at the next edge and beatCnt = 0.
REQ-032 rst asserted between clock edges during OWN1 -> gnt1, busValid and sel drop to 0 before the next edge; after release with req1 = 1 only, gnt1 returns 1 cycle later.
